// File: rtl/wb_write_queue_pkg.sv
// Shared sizing and the write-back entry layout for the write-back queue.
package wb_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned NUM_REGS  = 8;
  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned DEPTH     = 4;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/wb_write_queue_if.sv
// Push channel plus register-file write port of the write-back queue.
interface wb_write_queue_if #(
  parameter int unsigned NUM_REGS = wb_pkg::NUM_REGS,
  parameter int unsigned DATA_W   = wb_pkg::DATA_W
);
  import wb_pkg::*;

  logic                 inValid;
  logic                 inReady;
  logic [REG_IDX_W-1:0] inReg;
  logic [DATA_W-1:0]    inData;
  logic                 wbHold;
  logic                 regWrite;
  logic [NUM_REGS-1:0]  decOut;
  logic [DATA_W-1:0]    writeData;

  modport master (
    output inValid, inReg, inData, wbHold,
    input  inReady, regWrite, decOut, writeData
  );

  modport slave (
    input  inValid, inReg, inData, wbHold,
    output inReady, regWrite, decOut, writeData
  );

endinterface

// File: rtl/wb_write_queue_fifo.sv
// wb_fifo: circular storage, pointers and occupancy for the write-back queue.
// Caller guarantees push only when not full and pop only when not empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH   = wb_pkg::DEPTH,
  parameter type         entry_t = wb_pkg::wb_entry_t,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  entry_t           wdata_i,
  output entry_t           entries_o [DEPTH],
  output logic [PTR_W-1:0] rd_ptr_o,
  output logic [CNT_W-1:0] count_o
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Storage has no reset; validity comes solely from the pointers and count.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Next pointers and occupancy; pointers wrap naturally at power-of-two DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign entries_o = mem_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign count_o   = count_q;

endmodule

// File: rtl/wb_write_queue.sv
// wb_write_queue: FIFO of register write-backs drained one per cycle into the
// register file, with one-hot register select.
// Optional macro WB_BYPASS_EN builds a combinational forwarding lookup
// (youngest matching queued entry); otherwise fwdHit/fwdData are tied low.
module wb_write_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH    = wb_pkg::DEPTH,
  parameter int unsigned NUM_REGS = wb_pkg::NUM_REGS,
  parameter int unsigned DATA_W   = wb_pkg::DATA_W,
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_write_queue_if.slave      bus,
  output logic [CNT_W-1:0]     count,
  input  logic [REG_IDX_W-1:0] rdReg,
  output logic                 fwdHit,
  output logic [DATA_W-1:0]    fwdData
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [DATA_W-1:0]    data;
  } entry_t;

  entry_t           entries [DEPTH];
  entry_t           head;
  entry_t           in_entry;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             drain;

  assign in_entry    = '{idx: bus.inReg, data: bus.inData};
  assign bus.inReady = (count < CNT_W'(DEPTH));
  assign push        = bus.inValid && bus.inReady;
  // Gating with reset makes the write port drop immediately on assertion.
  assign drain       = (count != '0) && !bus.wbHold && !reset;
  assign head        = entries[rd_ptr];

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset),
    .push_i    (push),
    .pop_i     (drain),
    .wdata_i   (in_entry),
    .entries_o (entries),
    .rd_ptr_o  (rd_ptr),
    .count_o   (count)
  );

  // Register-file write port: head entry decoded while draining, else all zero.
  always_comb begin
    bus.regWrite  = drain;
    bus.decOut    = '0;
    bus.writeData = '0;
    if (drain) begin
      bus.decOut    = NUM_REGS'(1) << head.idx;
      bus.writeData = head.data;
    end
  end

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    logic [PTR_W-1:0] slot;
    slot    = '0;
    fwdHit  = 1'b0;
    fwdData = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      slot = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (entries[slot].idx == rdReg)) begin
        fwdHit  = 1'b1;
        fwdData = entries[slot].data;
      end
    end
  end
`else
  logic unused_rdreg;
  assign unused_rdreg = ^rdReg;
  assign fwdHit       = 1'b0;
  assign fwdData      = '0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: accepted pushes are queued as expected
// writes and compared against each register-file write as it appears.
module tb_wb_write_queue;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned DATA_W   = 16;

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  count;
  logic [2:0]  rdReg = '0;
  logic        fwdHit;
  logic [15:0] fwdData;

  int n_checks = 0;
  int n_pass   = 0;
  sb_t sb [$];

  wb_write_queue_if #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W)) bus ();

  wb_write_queue #(
    .DEPTH    (DEPTH),
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .count   (count),
    .rdReg   (rdReg),
    .fwdHit  (fwdHit),
    .fwdData (fwdData)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard monitor: compares state against the queued model, then pops
  // the drained entry and records an accepted push.
  always @(negedge clk) begin
    int          sz;
    logic        exp_rw;
    logic        exp_hit;
    logic [15:0] exp_fd;
    sb_t         e;
    if (!reset) begin
      sz      = sb.size();
      exp_rw  = (sz != 0) && !bus.wbHold;
      exp_hit = 1'b0;
      exp_fd  = '0;
`ifdef WB_BYPASS_EN
      for (int i = 0; i < sz; i++) begin
        if (sb[i].idx == rdReg) begin
          exp_hit = 1'b1;
          exp_fd  = sb[i].data;
        end
      end
`endif
      check("count", 32'(count), 32'(sz));
      check("inReady", 32'(bus.inReady), 32'(sz < DEPTH));
      check("regWrite", 32'(bus.regWrite), 32'(exp_rw));
      check("onehot0", 32'($onehot0(bus.decOut)), 32'd1);
      check("fwdHit", 32'(fwdHit), 32'(exp_hit));
      check("fwdData", 32'(fwdData), 32'(exp_fd));
      if (exp_rw) begin
        e = sb.pop_front();
        check("decOut", 32'(bus.decOut), 32'(8'd1 << e.idx));
        check("writeData", 32'(bus.writeData), 32'(e.data));
      end else begin
        check("idle_decOut", 32'(bus.decOut), 32'd0);
        check("idle_writeData", 32'(bus.writeData), 32'd0);
      end
      if (bus.inValid && (sz < DEPTH)) sb.push_back('{idx: bus.inReg, data: bus.inData});
    end
  end

  task automatic drive(input logic v, input logic [2:0] r, input logic [15:0] d);
    bus.inValid = v;
    bus.inReg   = r;
    bus.inData  = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    drive(1'b0, 3'd0, 16'h0);
    bus.wbHold = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (count == 3'd0) done = 1'b1;
    end
    check("drain_count", 32'(count), 32'd0);
    check("drain_sb", 32'(sb.size()), 32'd0);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 3'd0, 16'h0);
    bus.wbHold = 1'b0;
    #3;
    check("rst_count", 32'(count), 32'd0);
    check("rst_regWrite", 32'(bus.regWrite), 32'd0);
    check("rst_decOut", 32'(bus.decOut), 32'd0);
    check("rst_writeData", 32'(bus.writeData), 32'd0);
    check("rst_fwdHit", 32'(fwdHit), 32'd0);
    check("rst_fwdData", 32'(fwdData), 32'd0);
    @(posedge clk);
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // Single push into an empty queue appears one cycle later.
    drive(1'b1, 3'd3, 16'hBEEF);
    next_cycle();
    drive(1'b0, 3'd0, 16'h0);
    @(negedge clk);
    check("lat_regWrite", 32'(bus.regWrite), 32'd1);
    check("lat_decOut", 32'(bus.decOut), 32'h08);
    check("lat_writeData", 32'(bus.writeData), 32'hBEEF);
    next_cycle();
    check("lat_count_after", 32'(count), 32'd0);

    // Fill under hold; fifth request is refused.
    bus.wbHold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 3'(i + 1), 16'hA000 + 16'(i));
      next_cycle();
    end
    check("full_count", 32'(count), 32'd4);
    check("full_inReady", 32'(bus.inReady), 32'd0);
    wait_drain();

    // Two writes to the same register; forwarding returns the younger.
    bus.wbHold = 1'b1;
    drive(1'b1, 3'd2, 16'h0001);
    next_cycle();
    drive(1'b1, 3'd2, 16'h0002);
    next_cycle();
    drive(1'b0, 3'd0, 16'h0);
    rdReg = 3'd2;
    #1;
`ifdef WB_BYPASS_EN
    check("fwd_hit", 32'(fwdHit), 32'd1);
    check("fwd_data", 32'(fwdData), 32'h0002);
`else
    check("fwd_hit", 32'(fwdHit), 32'd0);
    check("fwd_data", 32'(fwdData), 32'h0000);
`endif
    rdReg = 3'd6;
    #1;
    check("fwd_miss_hit", 32'(fwdHit), 32'd0);
    check("fwd_miss_data", 32'(fwdData), 32'd0);
    wait_drain();

    // Asynchronous reset with three entries queued.
    bus.wbHold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'(4 + i), 16'hC000 + 16'(i));
      next_cycle();
    end
    drive(1'b0, 3'd0, 16'h0);
    bus.wbHold = 1'b0;
    rdReg = 3'd4;
    #1;
    check("pre_rst_regWrite", 32'(bus.regWrite), 32'd1);
    check("pre_rst_count", 32'(count), 32'd3);
    #1;
    reset = 1'b1;
    sb.delete();
    #1;
    check("arst_regWrite", 32'(bus.regWrite), 32'd0);
    check("arst_decOut", 32'(bus.decOut), 32'd0);
    check("arst_writeData", 32'(bus.writeData), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_fwdHit", 32'(fwdHit), 32'd0);
    check("arst_fwdData", 32'(fwdData), 32'd0);
    @(posedge clk);
    next_cycle();
    reset = 1'b0;
    repeat (5) next_cycle();

    // Sustained push every cycle with concurrent drain; pointers wrap.
    bus.wbHold = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 3'(i), 16'h1000 + 16'(i * 7));
      @(negedge clk);
      if (i > 0) check("sustain_count", 32'(count), 32'd1);
      next_cycle();
    end
    wait_drain();

    // Mixed random traffic.
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
      bus.wbHold = ($urandom_range(0, 3) == 0);
      rdReg      = 3'($urandom_range(0, 7));
      next_cycle();
    end
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
